// File: rtl/star_field.sv
// Falling-star lane engine on the 100 Hz game tick: LANES independent
// spawn/fall/judge/shrink/miss state machines plus a shared combo counter.
module star_field #(
  parameter int LANES       = 4,
  parameter int H_BASE      = 255,
  parameter int H_PITCH     = 210,
  parameter int V_TOP       = 0,
  parameter int V_BOTTOM    = 480,
  parameter int SPEED       = 2,
  parameter int HIT_WIN     = 40,
  parameter int STAR_W      = 60,
  parameter int STAR_H      = 60,
  parameter int SHRINK_STEP = 4,
  parameter int MISS_HOLD   = 50
) (
  input  logic                 clk_100hz,
  input  logic                 rst,
  input  logic                 en,
  input  logic [LANES-1:0]     spawn,
  input  logic [LANES-1:0]     hit,
  output logic [10*LANES-1:0]  star_h,
  output logic [10*LANES-1:0]  star_v,
  output logic [10*LANES-1:0]  star_height,
  output logic [10*LANES-1:0]  star_width,
  output logic [3*LANES-1:0]   star_state,
  output logic [LANES-1:0]     hit_pulse,
  output logic [LANES-1:0]     miss_pulse,
  output logic [9:0]           combo
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FALL = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_MISS = 3'd3;

  localparam int CNT_W = (MISS_HOLD > 2) ? $clog2(MISS_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_HOLD - 1);

  localparam logic [9:0] V_TOP_C = 10'(V_TOP);
  localparam logic [9:0] V_BOT_C = 10'(V_BOTTOM);
  localparam logic [9:0] WIN_C   = 10'(V_BOTTOM - HIT_WIN);
  localparam logic [9:0] SPEED_C = 10'(SPEED);
  localparam logic [9:0] STEP_C  = 10'(SHRINK_STEP);
  localparam logic [9:0] HALF_C  = 10'(SHRINK_STEP / 2);
  localparam logic [9:0] W_C     = 10'(STAR_W);
  localparam logic [9:0] H_C     = 10'(STAR_H);

  // Next-tick event strobes of every lane; zero whenever en is low.
  logic [LANES-1:0] hit_d;
  logic [LANES-1:0] miss_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [9:0] BASE = 10'(H_BASE + i * H_PITCH);

    logic [2:0]       state_q, state_d;
    logic [9:0]       h_q, h_d, v_q, v_d, ht_q, ht_d, w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hp_q, hp_d, mp_q, mp_d;
    logic             in_win, overrun;

    assign in_win  = (v_q >= WIN_C);
    assign overrun = ({1'b0, v_q} + {1'b0, SPEED_C}) > {1'b0, V_BOT_C};

    always_ff @(posedge clk_100hz or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      if (en) begin
        case (state_q)
          S_IDLE: if (spawn[i]) state_d = S_FALL;
          S_FALL: begin
            if (hit[i] && in_win) state_d = S_HIT;
            else if (overrun)     state_d = S_MISS;
          end
          S_HIT:  if (ht_q <= STEP_C) state_d = S_IDLE;
          S_MISS: if (cnt_q == CNT_LAST) state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end

    always_comb begin
      h_d   = h_q;
      v_d   = v_q;
      ht_d  = ht_q;
      w_d   = w_q;
      cnt_d = cnt_q;
      hp_d  = 1'b0;
      mp_d  = 1'b0;
      if (en) begin
        case (state_q)
          S_IDLE: begin
            if (spawn[i]) begin
              h_d  = BASE;
              v_d  = V_TOP_C;
              ht_d = H_C;
              w_d  = W_C;
            end
          end
          S_FALL: begin
            // A judged hit freezes v; the miss check only applies without one.
            if (hit[i] && in_win) begin
              hp_d = 1'b1;
            end else if (overrun) begin
              v_d   = V_BOT_C;
              mp_d  = 1'b1;
              cnt_d = '0;
            end else begin
              v_d = v_q + SPEED_C;
            end
          end
          S_HIT: begin
            if (ht_q > STEP_C) begin
              ht_d = ht_q - STEP_C;
              w_d  = w_q - STEP_C;
              h_d  = h_q + HALF_C;
            end else begin
              h_d  = BASE;
              v_d  = V_TOP_C;
              ht_d = '0;
              w_d  = '0;
            end
          end
          S_MISS: begin
            if (cnt_q == CNT_LAST) begin
              h_d  = BASE;
              v_d  = V_TOP_C;
              ht_d = '0;
              w_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            h_d  = BASE;
            v_d  = V_TOP_C;
            ht_d = '0;
            w_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_100hz or negedge rst) begin
      if (!rst) begin
        h_q   <= BASE;
        v_q   <= V_TOP_C;
        ht_q  <= '0;
        w_q   <= '0;
        cnt_q <= '0;
        hp_q  <= 1'b0;
        mp_q  <= 1'b0;
      end else begin
        h_q   <= h_d;
        v_q   <= v_d;
        ht_q  <= ht_d;
        w_q   <= w_d;
        cnt_q <= cnt_d;
        hp_q  <= hp_d;
        mp_q  <= mp_d;
      end
    end

    assign hit_d[i]               = hp_d;
    assign miss_d[i]              = mp_d;
    assign star_h[10*i +: 10]      = h_q;
    assign star_v[10*i +: 10]      = v_q;
    assign star_height[10*i +: 10] = ht_q;
    assign star_width[10*i +: 10]  = w_q;
    assign star_state[3*i +: 3]    = state_q;
    assign hit_pulse[i]            = hp_q;
    assign miss_pulse[i]           = mp_q;
  end

  logic [9:0]  combo_q, combo_d, n_hit;
  logic [10:0] combo_sum;

  // Any miss breaks the streak; hits landing on the same tick start the new one.
  always_comb begin
    n_hit = '0;
    for (int k = 0; k < LANES; k++) n_hit = n_hit + 10'(hit_d[k]);
    combo_sum = {1'b0, combo_q} + {1'b0, n_hit};
    if (|miss_d)                  combo_d = n_hit;
    else if (combo_sum > 11'd999) combo_d = 10'd999;
    else                          combo_d = combo_sum[9:0];
  end

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) combo_q <= '0;
    else      combo_q <= combo_d;
  end

  assign combo = combo_q;

endmodule

// File: tb/tb_star_field.sv
// Bench for star_field: a default-parameter instance and a short-playfield
// instance, both compared every tick against a lane-age reference model.
module tb_star_field;

  localparam int L  = 4;
  localparam int NI = 2;

  localparam int P_HB [NI] = '{255, 10};
  localparam int P_HP [NI] = '{210, 100};
  localparam int P_VT [NI] = '{0, 0};
  localparam int P_VB [NI] = '{480, 40};
  localparam int P_HW [NI] = '{40, 40};
  localparam int P_SP [NI] = '{2, 3};
  localparam int P_SW [NI] = '{60, 60};
  localparam int P_SH [NI] = '{60, 60};
  localparam int P_SS [NI] = '{4, 20};
  localparam int P_MH [NI] = '{50, 5};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0][L-1:0]    sp, ht, o_hp, o_mp;
  logic [NI-1:0][10*L-1:0] o_h, o_v, o_ht, o_w;
  logic [NI-1:0][3*L-1:0]  o_st;
  logic [NI-1:0][9:0]      o_combo;

  star_field u_dut (
    .clk_100hz(clk), .rst(rst), .en(en), .spawn(sp[0]), .hit(ht[0]),
    .star_h(o_h[0]), .star_v(o_v[0]), .star_height(o_ht[0]), .star_width(o_w[0]),
    .star_state(o_st[0]), .hit_pulse(o_hp[0]), .miss_pulse(o_mp[0]), .combo(o_combo[0])
  );

  star_field #(
    .LANES(4), .H_BASE(10), .H_PITCH(100), .V_TOP(0), .V_BOTTOM(40), .SPEED(3),
    .HIT_WIN(40), .STAR_W(60), .STAR_H(60), .SHRINK_STEP(20), .MISS_HOLD(5)
  ) u_sat (
    .clk_100hz(clk), .rst(rst), .en(en), .spawn(sp[1]), .hit(ht[1]),
    .star_h(o_h[1]), .star_v(o_v[1]), .star_height(o_ht[1]), .star_width(o_w[1]),
    .star_state(o_st[1]), .hit_pulse(o_hp[1]), .miss_pulse(o_mp[1]), .combo(o_combo[1])
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each lane is a mode (0 idle, 1 fall, 2 hit, 3 miss) plus the number of
  // enabled ticks spent in it; geometry follows arithmetically from the age.
  int m_mode [NI][L];
  int m_age  [NI][L];
  int m_hv   [NI][L];
  int m_hp   [NI][L];
  int m_mp   [NI][L];
  int m_combo[NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_combo[i] = 0;
      for (int l = 0; l < L; l++) begin
        m_mode[i][l] = 0; m_age[i][l] = 0; m_hv[i][l] = 0;
        m_hp[i][l] = 0;   m_mp[i][l] = 0;
      end
    end
  endtask

  task automatic model_step();
    int nh, nm, v;
    for (int i = 0; i < NI; i++) begin
      nh = 0; nm = 0;
      for (int l = 0; l < L; l++) begin
        m_hp[i][l] = 0; m_mp[i][l] = 0;
        if (!en) continue;
        case (m_mode[i][l])
          0: if (sp[i][l]) begin m_mode[i][l] = 1; m_age[i][l] = 0; end
          1: begin
            v = P_VT[i] + P_SP[i] * m_age[i][l];
            if (ht[i][l] && v >= P_VB[i] - P_HW[i]) begin
              m_mode[i][l] = 2; m_age[i][l] = 0; m_hv[i][l] = v; m_hp[i][l] = 1; nh++;
            end else if (v + P_SP[i] > P_VB[i]) begin
              m_mode[i][l] = 3; m_age[i][l] = 0; m_mp[i][l] = 1; nm++;
            end else m_age[i][l]++;
          end
          2: begin
            if (P_SH[i] - P_SS[i] * m_age[i][l] > P_SS[i]) m_age[i][l]++;
            else m_mode[i][l] = 0;
          end
          default: begin
            m_age[i][l]++;
            if (m_age[i][l] == P_MH[i]) m_mode[i][l] = 0;
          end
        endcase
      end
      if (en) begin
        if (nm > 0) m_combo[i] = nh;
        else m_combo[i] = (m_combo[i] + nh > 999) ? 999 : m_combo[i] + nh;
      end
    end
  endtask

  function automatic int e_h(int i, int l);
    int base = P_HB[i] + l * P_HP[i];
    return (m_mode[i][l] == 2) ? base + (P_SS[i] / 2) * m_age[i][l] : base;
  endfunction

  function automatic int e_v(int i, int l);
    case (m_mode[i][l])
      1: return P_VT[i] + P_SP[i] * m_age[i][l];
      2: return m_hv[i][l];
      3: return P_VB[i];
      default: return P_VT[i];
    endcase
  endfunction

  function automatic int e_size(int i, int l, int full);
    case (m_mode[i][l])
      0: return 0;
      2: return full - P_SS[i] * m_age[i][l];
      default: return full;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- per-tick compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      for (int l = 0; l < L; l++) begin
        chk($sformatf("u%0d lane%0d state", i, l), int'(o_st[i][3*l +: 3]), m_mode[i][l]);
        chk($sformatf("u%0d lane%0d h", i, l), int'(o_h[i][10*l +: 10]), e_h(i, l));
        chk($sformatf("u%0d lane%0d v", i, l), int'(o_v[i][10*l +: 10]), e_v(i, l));
        chk($sformatf("u%0d lane%0d height", i, l), int'(o_ht[i][10*l +: 10]), e_size(i, l, P_SH[i]));
        chk($sformatf("u%0d lane%0d width", i, l), int'(o_w[i][10*l +: 10]), e_size(i, l, P_SW[i]));
        chk($sformatf("u%0d lane%0d hit_pulse", i, l), int'(o_hp[i][l]), m_hp[i][l]);
        chk($sformatf("u%0d lane%0d miss_pulse", i, l), int'(o_mp[i][l]), m_mp[i][l]);
      end
      chk($sformatf("u%0d combo", i), int'(o_combo[i]), m_combo[i]);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int lane_f(logic [10*L-1:0] bus, int l);
    return int'(bus[10*l +: 10]);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    sp = '0; ht = '0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < L; l++) begin
      chk("reset state", int'(o_st[0][3*l +: 3]), 0);
      chk("reset h", lane_f(o_h[0], l), 255 + 210 * l);
      chk("reset v", lane_f(o_v[0], l), 0);
      chk("reset height", lane_f(o_ht[0], l), 0);
    end
    chk("reset combo", int'(o_combo[0]), 0);
    rst = 1'b1; en = 1'b1;
    tick();

    // lane 0 falls all the way and misses
    sp[0] = 4'b0001; tick(); sp[0] = '0;
    chk("spawn state", int'(o_st[0][2:0]), 1);
    chk("spawn v", lane_f(o_v[0], 0), 0);
    repeat (240) tick();
    chk("fall v480", lane_f(o_v[0], 0), 480);
    chk("fall still FALL", int'(o_st[0][2:0]), 1);
    tick();
    chk("miss state", int'(o_st[0][2:0]), 3);
    chk("miss pulse", int'(o_mp[0][0]), 1);
    tick();
    chk("miss pulse drop", int'(o_mp[0][0]), 0);
    repeat (48) tick();
    chk("miss hold", int'(o_st[0][2:0]), 3);
    tick();
    chk("miss to idle", int'(o_st[0][2:0]), 0);
    chk("idle h", lane_f(o_h[0], 0), 255);
    chk("idle width", lane_f(o_w[0], 0), 0);

    // lane 1 hit at v=440, then shrinks back to idle
    sp[0] = 4'b0010; tick(); sp[0] = '0;
    repeat (220) tick();
    chk("lane1 v440", lane_f(o_v[0], 1), 440);
    ht[0] = 4'b0010; tick(); ht[0] = '0;
    chk("hit state", int'(o_st[0][5:3]), 2);
    chk("hit pulse", int'(o_hp[0][1]), 1);
    chk("combo 1", int'(o_combo[0]), 1);
    tick();
    chk("shrink1 height", lane_f(o_ht[0], 1), 56);
    chk("shrink1 h", lane_f(o_h[0], 1), 467);
    chk("hit pulse drop", int'(o_hp[0][1]), 0);
    repeat (13) tick();
    chk("shrink14 height", lane_f(o_ht[0], 1), 4);
    chk("shrink14 width", lane_f(o_w[0], 1), 4);
    chk("shrink14 h", lane_f(o_h[0], 1), 493);
    tick();
    chk("hit to idle", int'(o_st[0][5:3]), 0);
    chk("hit idle h", lane_f(o_h[0], 1), 465);

    // early hit and re-spawn ignored on lane 2; then lanes 2,3 hit together
    sp[0] = 4'b1100; tick(); sp[0] = '0;
    repeat (219) tick();
    chk("lane2 v438", lane_f(o_v[0], 2), 438);
    ht[0] = 4'b0100; sp[0] = 4'b0100; tick(); ht[0] = '0; sp[0] = '0;
    chk("early hit ignored", int'(o_st[0][8:6]), 1);
    chk("early hit v", lane_f(o_v[0], 2), 440);
    ht[0] = 4'b1100; tick(); ht[0] = '0;
    chk("combo 3", int'(o_combo[0]), 3);
    repeat (16) tick();

    // two hits plus a miss on one tick, then a lone hit
    sp[0] = 4'b1000; tick();
    sp[0] = 4'b0011; tick();
    sp[0] = 4'b0100; tick(); sp[0] = '0;
    repeat (238) tick();
    ht[0] = 4'b0011; tick();
    chk("mixed miss3", int'(o_mp[0][3]), 1);
    chk("mixed combo 2", int'(o_combo[0]), 2);
    ht[0] = 4'b0100; tick(); ht[0] = '0;
    chk("lone hit combo 3", int'(o_combo[0]), 3);
    repeat (60) tick();

    // pause mid-fall
    sp[0] = 4'b0001; tick(); sp[0] = '0;
    repeat (50) tick();
    chk("pause v100", lane_f(o_v[0], 0), 100);
    en = 1'b0; sp[0] = 4'b1110; ht[0] = 4'b1111;
    repeat (10) begin
      tick();
      chk("paused v", lane_f(o_v[0], 0), 100);
    end
    chk("paused spawn ignored", int'(o_st[0][5:3]), 0);
    en = 1'b1; sp[0] = '0; ht[0] = '0;
    tick();
    chk("resume v102", lane_f(o_v[0], 0), 102);

    // randomized traffic on both instances
    repeat (800) begin
      for (int l = 0; l < L; l++) begin
        sp[0][l] = ($urandom_range(0, 15) == 0);
        ht[0][l] = ($urandom_range(0, 3) == 0);
        sp[1][l] = ($urandom_range(0, 3) == 0);
        ht[1][l] = ($urandom_range(0, 5) == 0);
      end
      en = ($urandom_range(0, 19) != 0);
      tick();
    end
    sp = '0; ht = '0; en = 1'b1;
    repeat (300) tick();

    // asynchronous reset in the middle of a lane-3 shrink
    sp[0] = 4'b1000; tick(); sp[0] = '0;
    repeat (220) tick();
    ht[0] = 4'b1000; tick(); ht[0] = '0;
    repeat (3) tick();
    chk("lane3 in HIT", int'(o_st[0][11:9]), 2);
    #2 rst = 1'b0;
    #1;
    chk("async rst state", int'(o_st[0][11:9]), 0);
    chk("async rst h", lane_f(o_h[0], 3), 885);
    chk("async rst height", lane_f(o_ht[0], 3), 0);
    chk("async rst combo", int'(o_combo[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // saturate combo on the short-playfield instance
    for (int r = 0; r < 251; r++) begin
      sp[1] = 4'hF; tick(); sp[1] = '0;
      ht[1] = 4'hF; tick(); ht[1] = '0;
      if (r == 0) chk("sat combo 4", int'(o_combo[1]), 4);
      if (r == 250) chk("sat combo held", int'(o_combo[1]), 999);
      repeat (3) tick();
      if (r == 249) chk("sat combo 999", int'(o_combo[1]), 999);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/star_field.md
# star_field

Parametrised falling-star engine for the rhythm-game playfield, running on the 100 Hz game tick. It generalises the fixed four-lane star placement to LANES independent lanes. Each lane has its own spawn/fall/judge/shrink/miss state machine, and the block keeps a shared combo counter. Outputs feed the VGA star renderer (geometry) and the score/sound logic (event pulses).

## Interface
- LANES, 4, number of lanes
- H_BASE, 255, x of lane 0 star left edge
- H_PITCH, 210, x spacing between lanes; H_BASE+(LANES-1)*H_PITCH+STAR_W must be < 1024
- V_TOP, 0, spawn y
- V_BOTTOM, 480, judge line y
- SPEED, 2, pixels per tick
- HIT_WIN, 40, hit accepted while v >= V_BOTTOM-HIT_WIN
- STAR_W / STAR_H, 60 / 60, spawned star size
- SHRINK_STEP, 4, even; size decrement per tick in HIT
- MISS_HOLD, 50, ticks spent in MISS
- clk_100hz  in  1  game tick clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  advance enable (0 = pause)
- spawn  in  LANES  per-lane spawn request, level-sampled
- hit  in  LANES  per-lane key-judge strobe, level-sampled
- star_h / star_v / star_height / star_width  out  10*LANES  per-lane geometry, lane i in bits [10i+9:10i]
- star_state  out  3*LANES  per-lane state code
- hit_pulse / miss_pulse  out  LANES  one-tick event strobes
- combo  out  10  consecutive-hit count, saturates at 999

## Operation
- Lane state codes: IDLE=0, FALL=1, HIT=2, MISS=3. Codes 4-7 are unused and recover to IDLE.
- Lane base x: H_BASE+i*H_PITCH.
- IDLE:
  - h=base, v=V_TOP, height=width=0.
  - spawn[i] moves the lane to FALL with v=V_TOP, width=STAR_W, height=STAR_H.
- FALL:
  - Each tick, if v+SPEED > V_BOTTOM, go to MISS with v=V_BOTTOM and pulse miss_pulse[i]. Otherwise v += SPEED.
  - hit[i] with v >= V_BOTTOM-HIT_WIN (inclusive) goes to HIT and pulses hit_pulse[i]; v holds.
  - A hit in the window has priority over the miss condition.
  - A hit outside the window is ignored.
- HIT:
  - While height > SHRINK_STEP: height and width -= SHRINK_STEP, h += SHRINK_STEP/2, so the star stays centred.
  - Otherwise go to IDLE with IDLE values.
- MISS:
  - Geometry holds; a counter runs MISS_HOLD ticks, then the lane goes to IDLE.
- spawn outside IDLE and hit outside FALL are ignored and not queued.
- en=0: all registers hold, spawn/hit are ignored, pulses are 0.
- Combo update per tick, with H = number of hit pulses and M = number of miss pulses:
  - If M > 0, combo = H.
  - Otherwise combo = min(combo+H, 999).
- Arithmetic: all geometry is unsigned 10-bit and is never allowed to wrap; the parameter constraints guarantee this.

## Timing
- All outputs are registered. No combinational input-to-output path.
- Reset values: star_state=0, star_h=lane base, star_v=V_TOP, star_height=star_width=0, hit_pulse=miss_pulse=0, combo=0.
- Reset assertion clears all lanes immediately, mid-operation in any state.
- Reset deassertion takes effect at the next edge.
- Spawn sampled at edge t: FALL with v=V_TOP visible after edge t; first move at edge t+1.
- Fall timing with defaults:
  - v=480 after edge t+240.
  - MISS after edge t+241.
  - IDLE after edge t+291.
- hit sampled at edge t: state=HIT, hit_pulse and the combo update are all visible after edge t.
  - hit_pulse drops after edge t+1.
  - The first shrink happens at edge t+1.
- HIT with defaults: 14 shrink ticks reach height=4; IDLE after the 15th tick.
- Lanes are fully independent. Simultaneous events on any lane set are legal.

## Test plan
- Lane 0 spawn, no hit: v steps 0,2,…,480; miss_pulse[0] one tick at the 241st edge after spawn; MISS for 50 ticks; then IDLE, h=255, size 0.
- Lane 1 spawn, hit when v=440:
  - hit_pulse[1], combo 0→1.
  - Width/height go 60→56→…→4 while h goes 465→467→…→493.
  - IDLE on the 15th tick.
- Lane 2 hit at v=438: ignored, lane stays FALL. Spawn on lane 2 while FALL: ignored.
- Combo=3; same tick: hits on lanes 0,1 and a miss on lane 3 → combo=2. Next tick: hit on lane 2 alone → combo=3.
- en=0 for 10 ticks mid-fall at v=100: v stays 100, spawn/hit ignored; resumes at 102.
- rst low mid-HIT on lane 3: outputs immediately return to reset values (h=885, size 0, combo 0).
- Combo held at 999 plus a hit → stays 999.
